// File: rtl/breakout_pkg.sv
// Shared constants, state encoding and matrix type for the breakout game-state engine.
package breakout_pkg;

    localparam logic signed [10:0] FIELD_H     = 11'sd256;
    localparam logic signed [10:0] BALL_SZ     = 11'sd4;
    localparam logic signed [10:0] BALL_HALF   = 11'sd2;
    localparam logic signed [10:0] BALL_X_MAX  = 11'sd508;
    localparam logic signed [10:0] BALL_X_INIT = 11'sd254;
    localparam logic signed [10:0] SERVE_Y     = 11'sd236;
    localparam logic signed [10:0] SERVE_DX    = 11'sd30;
    localparam logic signed [10:0] PADDLE_W    = 11'sd64;
    localparam logic signed [10:0] PADDLE_HALF = 11'sd32;
    localparam logic signed [10:0] PADDLE_Y    = 11'sd240;
    localparam logic signed [10:0] PADDLE_MAX  = 11'sd448;
    localparam logic signed [10:0] PADDLE_INIT = 11'sd224;
    localparam logic signed [10:0] GRID_X0     = 11'sd96;
    localparam logic signed [10:0] GRID_X1     = 11'sd415;
    localparam logic signed [10:0] GRID_Y0     = 11'sd32;
    localparam logic signed [10:0] GRID_Y1     = 11'sd71;
    localparam int BLK_W_LOG2 = 5;
    localparam int BLK_H_LOG2 = 3;

    typedef enum logic [1:0] {SERVE, PLAY, WIN, LOSE} state_t;

    typedef logic [0:4][0:9] matrix_t;

    function automatic logic [5:0] popcount(input matrix_t m);
        logic [49:0] flat;
        logic [5:0]  n;
        flat = m;
        n    = '0;
        for (int i = 0; i < 50; i++) n = n + {5'd0, flat[i]};
        return n;
    endfunction

endpackage

// File: rtl/breakout_collide.sv
// One frame of ball physics: walls, a single block hit, paddle bounce and bottom miss.
module breakout_collide
    import breakout_pkg::*;
#(
    parameter int BALL_STEP = 2
) (
    input  logic signed [10:0] x,
    input  logic signed [10:0] y,
    input  logic               dx,
    input  logic               dy,
    input  logic signed [10:0] paddle,
    input  matrix_t            matrix,
    output logic signed [10:0] next_x,
    output logic signed [10:0] next_y,
    output logic               next_dx,
    output logic               next_dy,
    output logic [2:0]         hit_row,
    output logic [3:0]         hit_col,
    output logic               hit,
    output logic               miss
);

    localparam logic signed [10:0] STEP = 11'(BALL_STEP);

    logic signed [10:0] cx;
    logic signed [10:0] cy;
    logic               in_grid;

    always_comb begin
        next_x  = dx ? x + STEP : x - STEP;
        next_y  = dy ? y + STEP : y - STEP;
        next_dx = dx;
        next_dy = dy;
        hit     = 1'b0;

        if (next_x < 11'sd0) begin
            next_x  = 11'sd0;
            next_dx = 1'b1;
        end else if (next_x > BALL_X_MAX) begin
            next_x  = BALL_X_MAX;
            next_dx = 1'b0;
        end
        if (next_y < 11'sd0) begin
            next_y  = 11'sd0;
            next_dy = 1'b1;
        end

        // Block lookup uses the ball center at the wall-corrected position.
        cx      = next_x + BALL_HALF;
        cy      = next_y + BALL_HALF;
        in_grid = (cx >= GRID_X0) && (cx <= GRID_X1) && (cy >= GRID_Y0) && (cy <= GRID_Y1);
        hit_col = 4'((cx - GRID_X0) >>> BLK_W_LOG2);
        hit_row = 3'((cy - GRID_Y0) >>> BLK_H_LOG2);
        if (in_grid) hit = matrix[hit_row][hit_col];
        if (hit) begin
            next_dy = ~next_dy;
            next_y  = y;
        end

        if (next_dy && (y + BALL_SZ <= PADDLE_Y) && (next_y + BALL_SZ > PADDLE_Y) &&
            (next_x + BALL_SZ > paddle) && (next_x < paddle + PADDLE_W)) begin
            next_y  = PADDLE_Y - BALL_SZ;
            next_dy = 1'b0;
            next_dx = !(next_x + BALL_HALF < paddle + PADDLE_HALF);
        end

        miss = (next_y + BALL_SZ >= FIELD_H);
    end

endmodule

// File: rtl/breakout_engine.sv
// Frame-rate game state for the VGA path: block matrix, paddle, ball, lives and end flags.
module breakout_engine
    import breakout_pkg::*;
#(
    parameter int          PADDLE_STEP = 4,
    parameter int          BALL_STEP   = 2,
    parameter int          LIVES       = 3,
    parameter logic [49:0] INIT_MATRIX = 50'h3_FFFF_FFFF_FFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_launch,
    output matrix_t    breakout_matrix,
    output logic [8:0] paddle_pos,
    output logic [8:0] ball_pos_x,
    output logic [7:0] ball_pos_y,
    output logic       player_win,
    output logic       game_over,
    output logic [1:0] lives,
    output state_t     state
);

    localparam logic signed [10:0] PSTEP      = 11'(PADDLE_STEP);
    localparam logic [5:0]         INIT_COUNT = popcount(matrix_t'(INIT_MATRIX));

    state_t     state_q, state_n;
    matrix_t    matrix_q, matrix_n;
    logic [8:0] paddle_q, paddle_n, ball_x_q, ball_x_n;
    logic [7:0] ball_y_q, ball_y_n;
    logic       dx_q, dx_n, dy_q, dy_n;
    logic [1:0] lives_q, lives_n;
    logic [5:0] count_q, count_n;
    logic       win_q, win_n, over_q, over_n;
    logic       restart;

    logic signed [10:0] pad_mv, pad_new, ball_x_s, ball_y_s, nx, ny;
    logic               ndx, ndy, hit, miss;
    logic [2:0]         hit_row;
    logic [3:0]         hit_col;

    assign ball_x_s = $signed({2'b00, ball_x_q});
    assign ball_y_s = $signed({3'b000, ball_y_q});

    always_comb begin
        pad_mv = $signed({2'b00, paddle_q});
        if (btn_left && !btn_right)      pad_mv = pad_mv - PSTEP;
        else if (btn_right && !btn_left) pad_mv = pad_mv + PSTEP;
        pad_new = pad_mv;
        if (pad_mv < 11'sd0)           pad_new = 11'sd0;
        else if (pad_mv > PADDLE_MAX)  pad_new = PADDLE_MAX;
    end

    breakout_collide #(.BALL_STEP(BALL_STEP)) u_collide (
        .x       (ball_x_s),
        .y       (ball_y_s),
        .dx      (dx_q),
        .dy      (dy_q),
        .paddle  (pad_new),
        .matrix  (matrix_q),
        .next_x  (nx),
        .next_y  (ny),
        .next_dx (ndx),
        .next_dy (ndy),
        .hit_row (hit_row),
        .hit_col (hit_col),
        .hit     (hit),
        .miss    (miss)
    );

    // Next-state values assume a frame tick; the register only commits them on one.
    always_comb begin
        state_n  = state_q;
        matrix_n = matrix_q;
        paddle_n = paddle_q;
        ball_x_n = ball_x_q;
        ball_y_n = ball_y_q;
        dx_n     = dx_q;
        dy_n     = dy_q;
        lives_n  = lives_q;
        count_n  = count_q;
        win_n    = win_q;
        over_n   = over_q;
        restart  = 1'b0;
        case (state_q)
            SERVE: begin
                paddle_n = 9'(pad_new);
                ball_x_n = 9'(pad_new + SERVE_DX);
                ball_y_n = 8'(SERVE_Y);
                if (btn_launch) begin
                    state_n = PLAY;
                    dx_n    = 1'b1;
                    dy_n    = 1'b0;
                end
            end
            PLAY: begin
                paddle_n = 9'(pad_new);
                ball_x_n = 9'(nx);
                ball_y_n = 8'(ny);
                dx_n     = ndx;
                dy_n     = ndy;
                if (hit) begin
                    matrix_n[hit_row][hit_col] = 1'b0;
                    count_n = count_q - 6'd1;
                end
                if (hit && count_q == 6'd1) begin
                    win_n   = 1'b1;
                    state_n = WIN;
                end else if (miss) begin
                    if (lives_q > 2'd1) begin
                        lives_n  = lives_q - 2'd1;
                        state_n  = SERVE;
                        ball_x_n = 9'(pad_new + SERVE_DX);
                        ball_y_n = 8'(SERVE_Y);
                        dx_n     = 1'b1;
                        dy_n     = 1'b0;
                    end else begin
                        lives_n = 2'd0;
                        over_n  = 1'b1;
                        state_n = LOSE;
                    end
                end
            end
            default: restart = btn_launch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || (frame_tick && restart)) begin
            state_q  <= SERVE;
            matrix_q <= matrix_t'(INIT_MATRIX);
            paddle_q <= 9'(PADDLE_INIT);
            ball_x_q <= 9'(BALL_X_INIT);
            ball_y_q <= 8'(SERVE_Y);
            dx_q     <= 1'b1;
            dy_q     <= 1'b0;
            lives_q  <= 2'(LIVES);
            count_q  <= INIT_COUNT;
            win_q    <= 1'b0;
            over_q   <= 1'b0;
        end else if (frame_tick) begin
            state_q  <= state_n;
            matrix_q <= matrix_n;
            paddle_q <= paddle_n;
            ball_x_q <= ball_x_n;
            ball_y_q <= ball_y_n;
            dx_q     <= dx_n;
            dy_q     <= dy_n;
            lives_q  <= lives_n;
            count_q  <= count_n;
            win_q    <= win_n;
            over_q   <= over_n;
        end
    end

    assign breakout_matrix = matrix_q;
    assign paddle_pos      = paddle_q;
    assign ball_pos_x      = ball_x_q;
    assign ball_pos_y      = ball_y_q;
    assign player_win      = win_q;
    assign game_over       = over_q;
    assign lives           = lives_q;
    assign state           = state_q;

endmodule
